zx81_tape_save_capture: RTL and testbench

//  Decodes the ZX81 SAVE waveform (MIC level from the ZX81 core) into bytes and buffers them as a .P image.
//  The HPS reads the image back over the ioctl upload path (ioctl_rd/ioctl_din).

---
 rtl/zx81_tape_save_capture_pkg.sv | 34 +++
 rtl/zx81_tape_save_capture_if.sv | 18 +
 rtl/zx81_tape_save_capture_dpram.sv | 41 ++++
 rtl/zx81_tape_save_capture.sv | 227 ++++++++++++++++++++++
 tb/tb_zx81_tape_save_capture.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/zx81_tape_save_capture_pkg.sv
// ============================================================================
// Module   : zx81_tape_pkg
// Purpose  : Shared types and constants for the ZX81 SAVE waveform capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package zx81_tape_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSES = 2'd1,
        ST_GAP    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Pulse-count windows for a bit: 3..5 is a zero, 8..10 is a one.
    localparam logic [3:0] ZERO_MIN   = 4'd3;
    localparam logic [3:0] ZERO_MAX   = 4'd5;
    localparam logic [3:0] ONE_MIN    = 4'd8;
    localparam logic [3:0] ONE_MAX    = 4'd10;
    localparam logic [3:0] ONE_THRESH = 4'd7;
    localparam logic [3:0] PCNT_SAT   = 4'd15;

    function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned us);
        longint unsigned cyc;
        cyc = (longint'(clk_hz) * longint'(us)) / 64'd1_000_000;
        return cyc[31:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/zx81_tape_save_capture_if.sv
// ============================================================================
// Module   : zx81_tape_save_capture_if
// Purpose  : ioctl upload read bus between the HPS and the save capture block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface zx81_tape_save_capture_if;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;

    modport master (output ioctl_upload, ioctl_rd, ioctl_addr, input ioctl_din);
    modport slave  (input ioctl_upload, ioctl_rd, ioctl_addr, output ioctl_din);
endinterface

`default_nettype wire

// File: rtl/zx81_tape_save_capture_dpram.sv
// ============================================================================
// Module   : zx81_tape_save_capture_dpram
// Purpose  : Simple dual-port image buffer, one write port, registered read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zx81_tape_save_capture_dpram
    import zx81_tape_pkg::*;
#(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (rd_en) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/zx81_tape_save_capture.sv
// ============================================================================
// Module   : zx81_tape_save_capture
// Purpose  : Decodes the ZX81 MIC SAVE waveform into bytes and buffers a .P image.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zx81_tape_save_capture
    import zx81_tape_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 52_000_000,
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned PULSE_MIN_US = 50,
    parameter int unsigned BIT_GAP_US   = 700,
    parameter int unsigned END_GAP_US   = 50_000,
    parameter bit          STRIP_NAME   = 1'b1
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     rec_en,
    input  logic                     mic_in,
    zx81_tape_save_capture_if.slave  ioctl,
    output logic                     rec_active,
    output logic                     rec_done,
    output logic [ADDR_W:0]          rec_len,
    output logic                     rec_overflow,
    output logic                     rec_error
);

    localparam int unsigned PULSE_MIN = us_to_cycles(CLK_HZ, PULSE_MIN_US);
    localparam int unsigned BIT_GAP   = us_to_cycles(CLK_HZ, BIT_GAP_US);
    localparam int unsigned END_GAP   = us_to_cycles(CLK_HZ, END_GAP_US);
    localparam int unsigned TMR_W     = $clog2(END_GAP + 1);
    localparam int unsigned HI_W      = $clog2(PULSE_MIN + 1);

    localparam logic [HI_W-1:0]  PULSE_MIN_H = HI_W'(PULSE_MIN);
    localparam logic [TMR_W-1:0] BIT_GAP_T   = TMR_W'(BIT_GAP);
    localparam logic [TMR_W-1:0] END_GAP_T   = TMR_W'(END_GAP);
    localparam logic [ADDR_W:0]  CAPACITY    = {1'b1, {ADDR_W{1'b0}}};

    logic             mic_meta_q, mic_meta_d, mic_sync_q, mic_sync_d, mic_prev_q, mic_prev_d;
    logic             rec_en_q, rec_en_d;
    logic [HI_W-1:0]  hi_cnt_q, hi_cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    state_e           state_q, state_d;
    logic [3:0]       pcnt_q, pcnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       bcnt_q, bcnt_d;
    logic             name_done_q, name_done_d;
    logic [ADDR_W:0]  len_q, len_d;
    logic             done_q, done_d, ovf_q, ovf_d, err_q, err_d;
    logic             rd_ok_q, rd_ok_d;

    logic             w_fall, w_pulse, w_bit_done, w_bit_bad, w_bit_val, w_we, w_rd;
    logic [7:0]       w_new_byte, w_ram_rdata;

    always_comb begin
        mic_meta_d  = mic_in;
        mic_sync_d  = mic_meta_q;
        mic_prev_d  = mic_sync_q;
        rec_en_d    = rec_en;
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        shreg_d     = shreg_q;
        bcnt_d      = bcnt_q;
        name_done_d = name_done_q;
        len_d       = len_q;
        done_d      = done_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        rd_ok_d     = rd_ok_q;
        w_bit_done  = 1'b0;
        w_we        = 1'b0;

        w_fall  = mic_prev_q & ~mic_sync_q;
        w_pulse = w_fall && (hi_cnt_q >= PULSE_MIN_H);

        // High-time counter only needs to reach the minimum, so it saturates there.
        hi_cnt_d = '0;
        if (mic_sync_q) begin
            hi_cnt_d = (hi_cnt_q == PULSE_MIN_H) ? hi_cnt_q : hi_cnt_q + 1'b1;
        end
        timer_d = w_fall ? '0 : ((timer_q == END_GAP_T) ? timer_q : timer_q + 1'b1);

        w_bit_bad  = !(((pcnt_q >= ZERO_MIN) && (pcnt_q <= ZERO_MAX)) ||
                       ((pcnt_q >= ONE_MIN)  && (pcnt_q <= ONE_MAX)));
        w_bit_val  = (pcnt_q >= ONE_THRESH);
        w_new_byte = {shreg_q[6:0], w_bit_val};

        if (!rec_en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (w_pulse && !done_q) begin
                        state_d = ST_PULSES;
                        pcnt_d  = 4'd1;
                    end
                end
                ST_PULSES: begin
                    if (timer_q == BIT_GAP_T) begin
                        w_bit_done = 1'b1;
                        if (w_pulse) begin
                            pcnt_d = 4'd1;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else if (w_pulse && (pcnt_q != PCNT_SAT)) begin
                        pcnt_d = pcnt_q + 4'd1;
                    end
                end
                ST_GAP: begin
                    if (w_pulse) begin
                        state_d = ST_PULSES;
                        pcnt_d  = 4'd1;
                    end else if (timer_q == END_GAP_T) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        if (bcnt_q != 3'd0) begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
            endcase
        end

        if (w_bit_done) begin
            if (w_bit_bad) begin
                err_d = 1'b1;
            end
            shreg_d = w_new_byte;
            bcnt_d  = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
                if (STRIP_NAME && !name_done_q) begin
                    if (w_new_byte[7]) begin
                        name_done_d = 1'b1;
                    end
                end else if (len_q == CAPACITY) begin
                    ovf_d = 1'b1;
                end else begin
                    w_we  = 1'b1;
                    len_d = len_q + 1'b1;
                end
            end
        end

        if (rec_en && !rec_en_q) begin
            len_d       = '0;
            done_d      = 1'b0;
            ovf_d       = 1'b0;
            err_d       = 1'b0;
            name_done_d = 1'b0;
            bcnt_d      = 3'd0;
            w_we        = 1'b0;
        end

        w_rd = ioctl.ioctl_rd & ioctl.ioctl_upload;
        if (w_rd) begin
            rd_ok_d = (ioctl.ioctl_addr[24:ADDR_W] == '0) &&
                      ({1'b0, ioctl.ioctl_addr[ADDR_W-1:0]} < len_q);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mic_meta_q  <= 1'b0;
            mic_sync_q  <= 1'b0;
            mic_prev_q  <= 1'b0;
            rec_en_q    <= 1'b0;
            hi_cnt_q    <= '0;
            timer_q     <= '0;
            state_q     <= ST_IDLE;
            pcnt_q      <= 4'd0;
            shreg_q     <= 8'h00;
            bcnt_q      <= 3'd0;
            name_done_q <= 1'b0;
            len_q       <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            rd_ok_q     <= 1'b0;
        end else begin
            mic_meta_q  <= mic_meta_d;
            mic_sync_q  <= mic_sync_d;
            mic_prev_q  <= mic_prev_d;
            rec_en_q    <= rec_en_d;
            hi_cnt_q    <= hi_cnt_d;
            timer_q     <= timer_d;
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            shreg_q     <= shreg_d;
            bcnt_q      <= bcnt_d;
            name_done_q <= name_done_d;
            len_q       <= len_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            rd_ok_q     <= rd_ok_d;
        end
    end

    zx81_tape_save_capture_dpram #(
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_dpram (
        .clk   (clk_sys),
        .we    (w_we),
        .waddr (len_q[ADDR_W-1:0]),
        .wdata (w_new_byte),
        .rd_en (w_rd),
        .raddr (ioctl.ioctl_addr[ADDR_W-1:0]),
        .rdata (w_ram_rdata)
    );

    assign ioctl.ioctl_din = rd_ok_q ? w_ram_rdata : 8'h00;
    assign rec_active      = (state_q == ST_PULSES) || (state_q == ST_GAP);
    assign rec_done        = done_q;
    assign rec_len         = len_q;
    assign rec_overflow    = ovf_q;
    assign rec_error       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_zx81_tape_save_capture.sv
// ============================================================================
// Module   : tb_zx81_tape_save_capture
// Purpose  : Directed scoreboard bench for three capture configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zx81_tape_save_capture;

    logic clk = 1'b0;
    logic reset;
    logic rec_en;
    logic mic;

    logic        act_a, done_a, ovf_a, err_a;
    logic [14:0] len_a;
    logic        act_b, done_b, ovf_b, err_b;
    logic [14:0] len_b;
    logic        act_c, done_c, ovf_c, err_c;
    logic [4:0]  len_c;

    logic [7:0] din_a, din_b, din_c;
    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];
    logic [7:0] sb_c[$];
    bit  nd_a, nd_c, ovf_c_exp;
    int  n_checks = 0;
    int  n_errors = 0;

    zx81_tape_save_capture_if if_a ();
    zx81_tape_save_capture_if if_b ();
    zx81_tape_save_capture_if if_c ();

    always #5 clk = ~clk;

    zx81_tape_save_capture #(.CLK_HZ(1_000_000), .ADDR_W(14), .PULSE_MIN_US(8),
        .BIT_GAP_US(40), .END_GAP_US(300), .STRIP_NAME(1'b1)) dut_a (
        .clk_sys(clk), .reset(reset), .rec_en(rec_en), .mic_in(mic), .ioctl(if_a),
        .rec_active(act_a), .rec_done(done_a), .rec_len(len_a),
        .rec_overflow(ovf_a), .rec_error(err_a));

    zx81_tape_save_capture #(.CLK_HZ(1_000_000), .ADDR_W(14), .PULSE_MIN_US(8),
        .BIT_GAP_US(40), .END_GAP_US(300), .STRIP_NAME(1'b0)) dut_b (
        .clk_sys(clk), .reset(reset), .rec_en(rec_en), .mic_in(mic), .ioctl(if_b),
        .rec_active(act_b), .rec_done(done_b), .rec_len(len_b),
        .rec_overflow(ovf_b), .rec_error(err_b));

    zx81_tape_save_capture #(.CLK_HZ(1_000_000), .ADDR_W(4), .PULSE_MIN_US(8),
        .BIT_GAP_US(40), .END_GAP_US(300), .STRIP_NAME(1'b1)) dut_c (
        .clk_sys(clk), .reset(reset), .rec_en(rec_en), .mic_in(mic), .ioctl(if_c),
        .rec_active(act_c), .rec_done(done_c), .rec_len(len_c),
        .rec_overflow(ovf_c), .rec_error(err_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: what each configuration should store for a decoded byte.
    task automatic expect_byte(input logic [7:0] b);
        if (nd_a) sb_a.push_back(b);
        else if (b[7]) nd_a = 1'b1;
        sb_b.push_back(b);
        if (nd_c) begin
            if (sb_c.size() < 16) sb_c.push_back(b);
            else ovf_c_exp = 1'b1;
        end else if (b[7]) begin
            nd_c = 1'b1;
        end
    endtask

    task automatic pulse(input bit glitch);
        mic = 1'b1;
        repeat (10) @(negedge clk);
        mic = 1'b0;
        if (glitch) begin
            repeat (4) @(negedge clk);
            mic = 1'b1;
            repeat (3) @(negedge clk);
            mic = 1'b0;
            repeat (4) @(negedge clk);
        end else begin
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic send_bit_n(input int n, input bit glitch);
        for (int p = 0; p < n; p++) pulse(glitch);
        repeat (60) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit glitch);
        for (int i = 7; i >= 0; i--) send_bit_n(b[i] ? 9 : 4, glitch);
        expect_byte(b);
    endtask

    task automatic read_all(input logic [24:0] addr);
        @(negedge clk);
        if_a.ioctl_addr = addr; if_b.ioctl_addr = addr; if_c.ioctl_addr = addr;
        if_a.ioctl_rd = 1'b1;   if_b.ioctl_rd = 1'b1;   if_c.ioctl_rd = 1'b1;
        @(negedge clk);
        if_a.ioctl_rd = 1'b0;   if_b.ioctl_rd = 1'b0;   if_c.ioctl_rd = 1'b0;
        din_a = if_a.ioctl_din; din_b = if_b.ioctl_din; din_c = if_c.ioctl_din;
    endtask

    // Reads addresses 0..upto-1; beyond the modelled image every read must return 0.
    task automatic drain(input int upto);
        logic [7:0] e;
        for (int i = 0; i < upto; i++) begin
            read_all(25'(i));
            e = 8'h00; if (sb_a.size() != 0) e = sb_a.pop_front();
            check($sformatf("ram_a[%0d]", i), 32'(din_a), 32'(e));
            e = 8'h00; if (sb_b.size() != 0) e = sb_b.pop_front();
            check($sformatf("ram_b[%0d]", i), 32'(din_b), 32'(e));
            e = 8'h00; if (sb_c.size() != 0) e = sb_c.pop_front();
            check($sformatf("ram_c[%0d]", i), 32'(din_c), 32'(e));
        end
    endtask

    task automatic check_lens();
        check("len_a", 32'(len_a), 32'(sb_a.size()));
        check("len_b", 32'(len_b), 32'(sb_b.size()));
        check("len_c", 32'(len_c), 32'(sb_c.size()));
    endtask

    task automatic rearm();
        @(negedge clk);
        rec_en = 1'b0;
        repeat (2) @(negedge clk);
        rec_en = 1'b1;
        @(negedge clk);
        nd_a = 1'b0; nd_c = 1'b0; ovf_c_exp = 1'b0;
        sb_a.delete(); sb_b.delete(); sb_c.delete();
    endtask

    initial begin
        reset = 1'b1; rec_en = 1'b0; mic = 1'b0;
        if_a.ioctl_upload = 1'b1; if_b.ioctl_upload = 1'b1; if_c.ioctl_upload = 1'b1;
        if_a.ioctl_rd = 1'b0;     if_b.ioctl_rd = 1'b0;     if_c.ioctl_rd = 1'b0;
        if_a.ioctl_addr = '0;     if_b.ioctl_addr = '0;     if_c.ioctl_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_active", 32'(act_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_len", 32'(len_a), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_din", 32'(if_a.ioctl_din), 32'd0);
        reset = 1'b0;

        // Name byte then two data bytes
        rearm();
        send_byte(8'hA6, 1'b0);
        check("s1_active_gap", 32'(act_a), 32'd1);
        check("s1_name_len_a", 32'(len_a), 32'd0);
        check("s1_name_len_b", 32'(len_b), 32'd1);
        send_byte(8'h3C, 1'b0);
        send_byte(8'hFF, 1'b0);
        repeat (350) @(negedge clk);
        check("s1_done_a", 32'(done_a), 32'd1);
        check("s1_active_a", 32'(act_a), 32'd0);
        check("s1_err_a", 32'(err_a), 32'd0);
        check("s1_ovf_a", 32'(ovf_a), 32'd0);
        check_lens();
        drain(4);
        read_all(25'h100_0001);
        check("s1_hi_addr", 32'(din_a), 32'd0);

        // Invalid pulse counts 6 and 7 inside a data byte
        rearm();
        send_byte(8'h80, 1'b0);
        send_bit_n(9, 1'b0); send_bit_n(4, 1'b0);
        send_bit_n(6, 1'b0); send_bit_n(7, 1'b0);
        for (int i = 0; i < 4; i++) send_bit_n(4, 1'b0);
        expect_byte(8'h90);
        repeat (350) @(negedge clk);
        check("s2_err_a", 32'(err_a), 32'd1);
        check("s2_done_a", 32'(done_a), 32'd1);
        check_lens();
        drain(3);

        // Short glitches ignored; drop rec_en mid-byte
        rearm();
        send_byte(8'h80, 1'b1);
        send_byte(8'h5A, 1'b1);
        check("s3_err_a", 32'(err_a), 32'd0);
        for (int i = 0; i < 4; i++) send_bit_n(9, 1'b0);
        rec_en = 1'b0;
        @(negedge clk);
        check("s3_drop_active", 32'(act_a), 32'd0);
        check_lens();
        drain(3);

        // Overflow on the 16-byte buffer
        rearm();
        check("s4_rearm_len", 32'(len_a), 32'd0);
        check("s4_rearm_done", 32'(done_a), 32'd0);
        check("s4_rearm_err", 32'(err_a), 32'd0);
        send_byte(8'hA6, 1'b0);
        for (int i = 0; i < 20; i++) send_byte(8'(i), 1'b0);
        repeat (350) @(negedge clk);
        check("s4_ovf_c", 32'(ovf_c), 32'(ovf_c_exp));
        check("s4_ovf_a", 32'(ovf_a), 32'd0);
        check("s4_err_c", 32'(err_c), 32'd0);
        check("s4_done_c", 32'(done_c), 32'd1);
        check_lens();
        drain(22);

        // Reset while collecting pulses
        rearm();
        send_byte(8'h80, 1'b0);
        send_byte(8'h01, 1'b0);
        for (int p = 0; p < 3; p++) pulse(1'b0);
        read_all(25'd0);
        check("s5_rd_a", 32'(din_a), 32'h01);
        check("s5_active", 32'(act_a), 32'd1);
        check("s5_len", 32'(len_a), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("s5_rst_active", 32'(act_a), 32'd0);
        check("s5_rst_len", 32'(len_a), 32'd0);
        check("s5_rst_done", 32'(done_a), 32'd0);
        check("s5_rst_err", 32'(err_a), 32'd0);
        check("s5_rst_ovf", 32'(ovf_a), 32'd0);
        check("s5_rst_din", 32'(if_a.ioctl_din), 32'd0);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
